// File: rtl/hazard_stall_unit.sv
// Hazard/stall generator: load-use, branch redirect, mem-wait and divider stalls.
// Optional perf counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_stall_unit #(
  parameter int DIV_LATENCY = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic                  exe_mem_read,
  input  logic                  exe_branch_taken,
  input  logic                  div_start,
  input  logic                  flush,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  load_hazard,
  output logic                  branch_hazard,
  output logic                  stall_pipl,
  output logic                  div_done,
  output logic                  mem_timeout_err,
  output logic [31:0]           perf_stall_cnt,
  output logic [31:0]           perf_load_cnt
);

  localparam int DCW = $clog2(DIV_LATENCY);

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_ERR
  } mem_st_t;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_st_t;

  mem_st_t        mem_st;
  div_st_t        div_st;
  logic [7:0]     mem_cnt;
  logic [DCW-1:0] div_cnt;
  logic           mem_stall;
  logic           div_stall;
  logic           rs_match;

  assign mem_stall = (mem_st != MEM_ERR) & mem_req & ~mem_ack;

  // flush kills the divide in the same cycle it is seen
  assign div_stall = ~flush &
    ((div_st == DIV_RUN) | ((div_st == DIV_IDLE) & div_start));

  assign stall_pipl = mem_stall | div_stall;

  assign rs_match =
    (id_rs1_used & (id_rs1 == exe_rd)) |
    (id_rs2_used & (id_rs2 == exe_rd));

  assign load_hazard = ~stall_pipl & exe_mem_read &
    (exe_rd != '0) & rs_match;

  assign branch_hazard = exe_branch_taken & ~stall_pipl;

  assign div_done        = (div_st == DIV_DONE);
  assign mem_timeout_err = (mem_st == MEM_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_st  <= MEM_IDLE;
      mem_cnt <= '0;
    end else begin
      unique case (mem_st)
        MEM_IDLE: begin
          if (mem_stall) begin
            mem_st  <= MEM_WAIT;
            mem_cnt <= 8'd1;
          end
        end
        MEM_WAIT: begin
          if (mem_ack | ~mem_req)
            mem_st <= MEM_IDLE;
          else if (mem_cnt == 8'(MEM_TIMEOUT))
            mem_st <= MEM_ERR;
          else
            mem_cnt <= mem_cnt + 8'd1;
        end
        MEM_ERR:  mem_st <= MEM_IDLE;
        default:  mem_st <= MEM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_st  <= DIV_IDLE;
      div_cnt <= '0;
    end else if (flush) begin
      div_st <= DIV_IDLE;
    end else begin
      unique case (div_st)
        DIV_IDLE: begin
          if (div_start) begin
            div_st  <= DIV_RUN;
            div_cnt <= DCW'(DIV_LATENCY - 2);
          end
        end
        DIV_RUN: begin
          if (div_cnt == '0)
            div_st <= DIV_DONE;
          else
            div_cnt <= div_cnt - 1'b1;
        end
        // result is held until a concurrent mem stall lets the pipe advance
        DIV_DONE: begin
          if (!mem_stall)
            div_st <= DIV_IDLE;
        end
        default: div_st <= DIV_IDLE;
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_load_cnt  <= '0;
    end else begin
      if (stall_pipl)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (load_hazard)
        perf_load_cnt <= perf_load_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_load_cnt  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit (DIV_LATENCY=4, MEM_TIMEOUT=4).
// Driver pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, exe_rd;
  logic       id_rs1_used, id_rs2_used;
  logic       exe_mem_read, exe_branch_taken;
  logic       div_start, flush, mem_req, mem_ack;
  logic       load_hazard, branch_hazard, stall_pipl;
  logic       div_done, mem_timeout_err;
  logic [31:0] perf_stall_cnt, perf_load_cnt;

  always #5 clk = ~clk;

  hazard_stall_unit #(
    .DIV_LATENCY(4),
    .MEM_TIMEOUT(4),
    .REG_ADDR_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .id_rs1(id_rs1),
    .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used),
    .id_rs2_used(id_rs2_used),
    .exe_rd(exe_rd),
    .exe_mem_read(exe_mem_read),
    .exe_branch_taken(exe_branch_taken),
    .div_start(div_start),
    .flush(flush),
    .mem_req(mem_req),
    .mem_ack(mem_ack),
    .load_hazard(load_hazard),
    .branch_hazard(branch_hazard),
    .stall_pipl(stall_pipl),
    .div_done(div_done),
    .mem_timeout_err(mem_timeout_err),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_load_cnt(perf_load_cnt)
  );

  typedef struct packed {
    logic [4:0]  o;
    logic        chk_perf;
    logic [31:0] ps;
    logic [31:0] pl;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // o = {load_hazard, branch_hazard, stall_pipl, div_done, mem_timeout_err}
  task automatic expect_o(input logic [4:0] o);
    exp_t e;
    e.o        = o;
    e.chk_perf = 1'b0;
    e.ps       = '0;
    e.pl       = '0;
    q.push_back(e);
  endtask

  task automatic expect_p(input logic [4:0] o,
                          input int ps, input int pl);
    exp_t e;
    e.o        = o;
    e.chk_perf = 1'b1;
`ifdef HAZARD_PERF_CNT_EN
    e.ps = 32'(ps);
    e.pl = 32'(pl);
`else
    e.ps = '0;
    e.pl = '0;
    if (ps < 0 || pl < 0) e.ps = '0;
`endif
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] act;
      e   = q.pop_front();
      act = {load_hazard, branch_hazard, stall_pipl,
             div_done, mem_timeout_err};
      checks++;
      if (act !== e.o) begin
        errors++;
        $display("FAIL outs cyc=%0d got=%b want=%b (lh bh st dd err)",
                 cyc, act, e.o);
      end
      if (e.chk_perf) begin
        checks++;
        if (perf_stall_cnt !== e.ps || perf_load_cnt !== e.pl) begin
          errors++;
          $display("FAIL perf cyc=%0d got=%0d/%0d want=%0d/%0d",
                   cyc, perf_stall_cnt, perf_load_cnt, e.ps, e.pl);
        end
      end
    end
  end

  task automatic clr_in();
    id_rs1 = '0; id_rs2 = '0; exe_rd = '0;
    id_rs1_used = 0; id_rs2_used = 0;
    exe_mem_read = 0; exe_branch_taken = 0;
    div_start = 0; flush = 0; mem_req = 0; mem_ack = 0;
  endtask

  task automatic ld_stim();
    exe_mem_read = 1; exe_rd = 5'd5;
    id_rs1 = 5'd5; id_rs1_used = 1;
  endtask

  initial begin
    rst = 1;
    clr_in();
    tick(); tick();
    // reset state
    tick(); rst = 0; expect_p(5'b00000, 0, 0);

    // load-use on rs1, rd=0 suppression, rs2 match
    tick(); ld_stim(); expect_o(5'b10000);
    tick(); exe_rd = 5'd0; id_rs1 = 5'd0; expect_o(5'b00000);
    tick(); exe_rd = 5'd7; id_rs1 = 5'd5;
    id_rs2 = 5'd7; id_rs2_used = 1; expect_o(5'b10000);
    tick(); id_rs2_used = 0; expect_o(5'b00000);
    tick(); clr_in(); exe_branch_taken = 1; expect_o(5'b01000);

    // clean reset before perf scenario
    tick(); clr_in(); rst = 1; expect_o(5'b00000);
    tick(); rst = 0; expect_p(5'b00000, 0, 0);

    // 3-cycle mem wait, ack ends stall in ack cycle
    tick(); mem_req = 1; expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); mem_ack = 1; expect_o(5'b00000);
    tick(); clr_in(); expect_o(5'b00000);
    tick(); ld_stim(); expect_o(5'b10000);
    tick(); clr_in(); expect_p(5'b00000, 3, 1);

    // load hazard masked while frozen, then allowed
    tick(); ld_stim(); mem_req = 1; expect_o(5'b00100);
    tick(); mem_ack = 1; expect_o(5'b10000);
    tick(); clr_in(); expect_p(5'b00000, 4, 2);

    // timeout: 5 stall cycles, then 1-cycle error, late ack ignored
    tick(); mem_req = 1; expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); exe_branch_taken = 1; expect_o(5'b00100);
    tick(); exe_branch_taken = 0; expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); mem_ack = 1; expect_o(5'b00001);
    tick(); clr_in(); expect_o(5'b00000);

    // back-to-back divides
    tick(); div_start = 1; expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); expect_o(5'b00010);
    tick(); expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); expect_o(5'b00010);
    tick(); div_start = 0; expect_o(5'b00000);

    // flush during DIV_RUN
    tick(); div_start = 1; expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); div_start = 0; flush = 1; expect_o(5'b00000);
    tick(); flush = 0; expect_o(5'b00000);
    tick(); expect_o(5'b00000);

    // divide finishes under mem stall: DIV_DONE held until ack
    tick(); div_start = 1; expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); mem_req = 1; expect_o(5'b00100);
    tick(); expect_o(5'b00110);
    tick(); expect_o(5'b00110);
    tick(); mem_ack = 1; expect_o(5'b00010);
    tick(); clr_in(); expect_o(5'b00000);
    tick(); expect_o(5'b00000);

    // reset abandons mem wait and divide without error pulse
    tick(); mem_req = 1; div_start = 1; expect_o(5'b00100);
    tick(); expect_o(5'b00100);
    tick(); rst = 1; expect_o(5'b00100);
    tick(); rst = 0; clr_in(); expect_p(5'b00000, 0, 0);
    tick(); expect_o(5'b00000);

    tick();
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
